// File: rtl/uart_pkg.sv
// Purpose : shared definitions for the UART receive path: FSM state encoding,
//           legal prescale range and a helper that coerces prescale into it.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
//
// Build option: UART_RX_PARITY_EN adds the PARITY state to the encoding.
// Without it the state is absent, so no logic can reach it.
package uart_pkg;

    // Legal clocks-per-bit range. The value must be even so the mid-bit
    // sample point P/2-1 is exact.
    localparam int unsigned PRESCALE_MIN = 4;
    localparam int unsigned PRESCALE_MAX = 32;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
    } rx_state_t;
`endif

    // Coerce an arbitrary prescale into the legal range: drop the LSB to make
    // it even, then clamp. Legal inputs pass through unchanged; illegal ones
    // still give a well-formed bit period instead of a wedged counter.
    function automatic int unsigned legal_prescale(input int unsigned p);
        int unsigned q;
        q = p & ~32'd1;
        if (q < PRESCALE_MIN) begin
            q = PRESCALE_MIN;
        end else if (q > PRESCALE_MAX) begin
            q = PRESCALE_MAX;
        end
        return q;
    endfunction

endpackage

// File: rtl/uart_edge_bit_counter.sv
// Purpose : bit-timing counters for the UART receiver. edge_cnt runs 0..P-1
//           inside each bit and wraps; bit_cnt counts data bits 0..DATA_SIZE-1.
// Latency : flags are combinational decodes of the registered counters.
// Backpr. : none; the FSM gates counting through i_edge_en / i_bit_en.
//
// Ports
//   clk, rst        : clock, asynchronous active-low reset
//   i_clr           : synchronous clear of both counters (held while idle)
//   i_edge_en       : advance edge_cnt this cycle
//   i_bit_en        : advance bit_cnt when edge_cnt wraps
//   i_prescale      : latched clocks-per-bit P (even, 4..32)
//   o_edge_mid      : edge_cnt == P/2-1, the single sample point of a bit
//   o_edge_last     : edge_cnt == P-1, the last cycle of a bit
//   o_bit_last      : bit_cnt == DATA_SIZE-1
module uart_edge_bit_counter #(
    parameter int DATA_SIZE  = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_edge_en,
    input  logic                  i_bit_en,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_edge_mid,
    output logic                  o_edge_last,
    output logic                  o_bit_last
);

    // A single-bit frame still needs a one-bit counter.
    localparam int BIT_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [PRESCALE_W-1:0] w_mid_val;
    logic [PRESCALE_W-1:0] w_last_val;

    assign w_mid_val   = (i_prescale >> 1) - PRESCALE_W'(1);
    assign w_last_val  = i_prescale - PRESCALE_W'(1);

    assign o_edge_mid  = (r_edge_cnt == w_mid_val);
    assign o_edge_last = (r_edge_cnt == w_last_val);
    assign o_bit_last  = (r_bit_cnt == BIT_W'(DATA_SIZE - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (i_clr) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else begin
            if (i_edge_en) begin
                r_edge_cnt <= o_edge_last ? '0 : r_edge_cnt + PRESCALE_W'(1);
            end
            // bit_cnt moves on the bit boundary so it names the bit that the
            // next mid-point sample belongs to.
            if (i_bit_en && o_edge_last) begin
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// Purpose : UART receive FSM. Detects the start bit, samples each bit once at
//           mid-bit, strobes data bits to a deserializer and flags frame status.
// Latency : deser_en/deser_bit appear the cycle a sample is taken (registered);
//           the status pulse follows the stop-bit sample the same way.
// Backpr. : none; the serial line cannot be stalled, outputs are pulses.
//
// Ports
//   clk, rst    : clock, asynchronous active-low reset
//   rx_in       : synchronized serial line, idle high
//   prescale    : clocks per bit, latched at start detection
//   par_en      : frame carries a parity bit (latched at start detection)
//   par_typ     : 0 = even, 1 = odd parity (latched at start detection)
//   deser_en    : one-cycle shift strobe to the deserializer
//   deser_bit   : sampled data bit, valid with deser_en, LSB first
//   data_valid  : one-cycle pulse, frame received cleanly
//   par_err     : one-cycle pulse, parity mismatch
//   stp_err     : one-cycle pulse, stop bit sampled low
//
// Build option: define UART_RX_PARITY_EN to include the PARITY state and the
// par_en/par_typ handling. Undefined, parity inputs are ignored, par_err is 0
// and the last data bit leads straight to STOP.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int DATA_SIZE  = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  deser_en,
    output logic                  deser_bit,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    rx_state_t             r_state;
    logic [PRESCALE_W-1:0] r_prescale;
    logic                  r_deser_en;
    logic                  r_deser_bit;
    logic                  r_data_valid;
    logic                  r_stp_err;

`ifdef UART_RX_PARITY_EN
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_par_acc;   // XOR of data bits seen so far
    logic                  r_par_pend;  // parity mismatch waiting for STOP
    logic                  r_par_err;
`else
    // Parity inputs have no function in this build.
    logic                  w_unused_par;
    assign w_unused_par = par_en ^ par_typ;
`endif

    logic                  w_cnt_clr;
    logic                  w_edge_en;
    logic                  w_bit_en;
    logic                  w_edge_mid;
    logic                  w_edge_last;
    logic                  w_bit_last;

    // Counters sit at zero whenever the FSM is idle, so the start-detection
    // cycle begins a bit period with edge_cnt already cleared.
    assign w_cnt_clr = (r_state == ST_IDLE);
    assign w_edge_en = (r_state != ST_IDLE);
    assign w_bit_en  = (r_state == ST_DATA);

    uart_edge_bit_counter #(
        .DATA_SIZE  (DATA_SIZE),
        .PRESCALE_W (PRESCALE_W)
    ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_cnt_clr),
        .i_edge_en   (w_edge_en),
        .i_bit_en    (w_bit_en),
        .i_prescale  (r_prescale),
        .o_edge_mid  (w_edge_mid),
        .o_edge_last (w_edge_last),
        .o_bit_last  (w_bit_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_prescale   <= PRESCALE_W'(PRESCALE_MIN);
            r_deser_en   <= 1'b0;
            r_deser_bit  <= 1'b0;
            r_data_valid <= 1'b0;
            r_stp_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
            r_par_acc    <= 1'b0;
            r_par_pend   <= 1'b0;
            r_par_err    <= 1'b0;
`endif
        end else begin
            // All strobes are single-cycle; they are re-armed only below.
            r_deser_en   <= 1'b0;
            r_data_valid <= 1'b0;
            r_stp_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err    <= 1'b0;
`endif

            case (r_state)
                ST_IDLE: begin
                    if (!rx_in) begin
                        // Frame configuration is frozen here; later changes on
                        // the inputs wait for the next start detection.
                        r_state    <= ST_START;
                        r_prescale <= PRESCALE_W'(legal_prescale(32'(prescale)));
`ifdef UART_RX_PARITY_EN
                        r_par_en   <= par_en;
                        r_par_typ  <= par_typ;
                        r_par_acc  <= 1'b0;
                        r_par_pend <= 1'b0;
`endif
                    end
                end

                ST_START: begin
                    // A high line at mid start bit was noise: drop silently.
                    if (w_edge_mid && rx_in) begin
                        r_state <= ST_IDLE;
                    end else if (w_edge_last) begin
                        r_state <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_edge_mid) begin
                        r_deser_en  <= 1'b1;
                        r_deser_bit <= rx_in;
`ifdef UART_RX_PARITY_EN
                        r_par_acc   <= r_par_acc ^ rx_in;
`endif
                    end
                    if (w_edge_last && w_bit_last) begin
`ifdef UART_RX_PARITY_EN
                        r_state <= r_par_en ? ST_PARITY : ST_STOP;
`else
                        r_state <= ST_STOP;
`endif
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    // Even parity expects the XOR of the data; odd its inverse.
                    // The verdict is only reported once the stop bit is seen.
                    if (w_edge_mid) begin
                        r_par_pend <= rx_in ^ (r_par_acc ^ r_par_typ);
                    end
                    if (w_edge_last) begin
                        r_state <= ST_STOP;
                    end
                end
`endif

                ST_STOP: begin
                    // Leave at the sample rather than the bit end so a start
                    // bit that follows the stop bit directly is not missed.
                    if (w_edge_mid) begin
                        r_state   <= ST_IDLE;
                        r_stp_err <= ~rx_in;
`ifdef UART_RX_PARITY_EN
                        r_par_err    <= r_par_pend;
                        r_data_valid <= rx_in & ~r_par_pend;
`else
                        r_data_valid <= rx_in;
`endif
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign deser_en   = r_deser_en;
    assign deser_bit  = r_deser_bit;
    assign data_valid = r_data_valid;
    assign stp_err    = r_stp_err;
`ifdef UART_RX_PARITY_EN
    assign par_err    = r_par_err;
`else
    assign par_err    = 1'b0;
`endif

endmodule
